// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver with a ready/valid hold register.
//
// Samples an asynchronous, idle-high serial line in the middle of each bit.
// It receives start + DATA_BITS (LSB first) + optional parity + STOP_BITS.
// The completed word and its error flags are held until the consumer accepts it.
//
// Optional feature macro: UART_RX_CFG_PARITY_EN
//   defined   -> a parity bit follows the data bits and is checked
//                (PARITY_ODD selects odd/even).
//   undefined -> there is no parity bit, and o_Parity_Err is tied 0.
//
// Parameters:
//   CLKS_PER_BIT  clocks per bit period (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    1 = odd parity, 0 = even parity (used only with the macro)
//
// Ports:
//   i_Clk         clock; all logic runs on the rising edge
//   i_Rst_L       synchronous reset, active low
//   i_RX_Serial   asynchronous serial input, idle high
//   i_RX_Ready    consumer is ready to take the held word
//   o_RX_Valid    o_RX_Data and the error flags are valid; held until accepted
//   o_RX_Data     received word
//   o_Frame_Err   the held word had a stop bit sampled low
//   o_Parity_Err  the held word failed the parity check
//   o_Overrun     one-cycle pulse when a completed frame is dropped
//   o_Busy        receiver is not idle

module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ready,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_cfg: illegal parameter combination");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 4;  // covers bit index 0..8 and stop index 0..1

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
`ifdef UART_RX_CFG_PARITY_EN
    PARITY  = 3'd3,
`endif
    STOP    = 3'd4,
    DELIVER = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rx_sync;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 frame_err_acc;
  logic                 bit_tick;
  logic                 accept_new;
  logic                 drop_new;

  // Two-flop synchronizer, reset to the idle (high) line level.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
    end
  end

  assign bit_tick = (clk_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_sync) state_nxt = START;
      START:   if (clk_cnt == CNT_HALF) state_nxt = rx_sync ? IDLE : DATA;
      DATA:    if (bit_tick && bit_idx == DATA_LAST)
`ifdef UART_RX_CFG_PARITY_EN
                 state_nxt = PARITY;
      PARITY:  if (bit_tick) state_nxt = STOP;
`else
                 state_nxt = STOP;
`endif
      // Completing at mid-stop leaves half a bit to return to IDLE and catch
      // a back-to-back start edge.
      STOP:    if (bit_tick && bit_idx == STOP_LAST) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and handshake decode.
  always_comb begin
    o_Busy     = (state != IDLE);
    accept_new = (state == DELIVER) && (!o_RX_Valid || i_RX_Ready);
    drop_new   = (state == DELIVER) && o_RX_Valid && !i_RX_Ready;
  end

  // Bit and clock counters, data shift register and the frame-error accumulator.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      clk_cnt       <= '0;
      bit_idx       <= '0;
      rx_shift      <= '0;
      frame_err_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt       <= '0;
          bit_idx       <= '0;
          frame_err_acc <= 1'b0;
        end
        START: begin
          if (clk_cnt == CNT_HALF) clk_cnt <= '0;
          else                     clk_cnt <= clk_cnt + 1'b1;
        end
        DATA: begin
          if (bit_tick) begin
            clk_cnt  <= '0;
            // LSB arrives first, so shift in from the top.
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            bit_idx  <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_RX_CFG_PARITY_EN
        PARITY: begin
          if (bit_tick) clk_cnt <= '0;
          else          clk_cnt <= clk_cnt + 1'b1;
        end
`endif
        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (!rx_sync) frame_err_acc <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Hold register: a new frame replaces the held word only when that word is
  // absent or being accepted this cycle; otherwise the new frame is dropped.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_RX_Valid  <= 1'b0;
      o_RX_Data   <= '0;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      o_Overrun <= 1'b0;
      if (accept_new) begin
        o_RX_Valid  <= 1'b1;
        o_RX_Data   <= rx_shift;
        o_Frame_Err <= frame_err_acc;
      end else if (drop_new) begin
        o_Overrun <= 1'b1;
      end else if (o_RX_Valid && i_RX_Ready) begin
        o_RX_Valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CFG_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);

  logic parity_err_acc;
  logic parity_err_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      parity_err_acc <= 1'b0;
      parity_err_q   <= 1'b0;
    end else begin
      if (state == IDLE)
        parity_err_acc <= 1'b0;
      else if (state == PARITY && bit_tick)
        parity_err_acc <= ((^rx_shift) ^ rx_sync) != PAR_ODD;
      if (accept_new) parity_err_q <= parity_err_acc;
    end
  end

  assign o_Parity_Err = parity_err_q;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg -- directed self-checking bench for uart_rx_cfg.
// Instance dut : CLKS_PER_BIT=8, 8 data bits, 1 stop bit.
// Instance dut5: CLKS_PER_BIT=8, 5 data bits, 2 stop bits.
// When UART_RX_CFG_PARITY_EN is defined, every frame carries a parity bit.
// By default that bit is correct even parity.

module tb_uart_rx_cfg;

`ifdef UART_RX_CFG_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int CPB = 8;

  logic clk;
  logic rst_n, line, ready;
  logic valid, ferr, perr, ovr, busy;
  logic [7:0] data;
  logic rst5_n, line5, ready5;
  logic valid5, ferr5, perr5, ovr5, busy5;
  logic [4:0] data5;

  int n_checks = 0;
  int n_fail   = 0;

  // Handshake / pulse monitors; values are those seen just before each edge.
  int acc_cnt = 0, ovr_cnt = 0, busy_run = 0, acc5_cnt = 0;
  logic [7:0] last_data = '0;
  logic       last_ferr = 1'b0, last_perr = 1'b0;
  logic [4:0] last5_data = '0;
  logic       last5_ferr = 1'b0;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_Serial(line), .i_RX_Ready(ready),
    .o_RX_Valid(valid), .o_RX_Data(data), .o_Frame_Err(ferr),
    .o_Parity_Err(perr), .o_Overrun(ovr), .o_Busy(busy)
  );

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) dut5 (
    .i_Clk(clk), .i_Rst_L(rst5_n), .i_RX_Serial(line5), .i_RX_Ready(ready5),
    .o_RX_Valid(valid5), .o_RX_Data(data5), .o_Frame_Err(ferr5),
    .o_Parity_Err(perr5), .o_Overrun(ovr5), .o_Busy(busy5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (valid && ready) begin
      acc_cnt   <= acc_cnt + 1;
      last_data <= data;
      last_ferr <= ferr;
      last_perr <= perr;
    end
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    busy_run <= busy ? busy_run + 1 : 0;
    if (valid5 && ready5) begin
      acc5_cnt   <= acc5_cnt + 1;
      last5_data <= data5;
      last5_ferr <= ferr5;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds the level for n bit-clocks.
  task automatic drive(input bit sel5, input logic v, input int n);
    if (sel5) line5 = v;
    else      line  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel5, input logic [8:0] d, input int nbits,
                            input logic par_bit, input logic stop_val, input int nstop);
    logic [8:0] dv;
    dv = d;
    drive(sel5, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive(sel5, dv[i], CPB);
    if (PAR) drive(sel5, par_bit, CPB);
    for (int i = 0; i < nstop; i++) drive(sel5, stop_val, CPB);
    if (sel5) line5 = 1'b1;
    else      line  = 1'b1;
  endtask

  initial begin
    int acc0, ovr0, bmax;
    rst_n = 1'b0; line = 1'b1; ready = 1'b1;
    rst5_n = 1'b0; line5 = 1'b1; ready5 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid",   valid, 0);
    chk("rst_data",    data,  0);
    chk("rst_ferr",    ferr,  0);
    chk("rst_perr",    perr,  0);
    chk("rst_overrun", ovr,   0);
    chk("rst_busy",    busy,  0);
    chk("rst5_valid",  valid5, 0);
    chk("rst5_busy",   busy5,  0);

    rst_n = 1'b1; rst5_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5, 8N1, consumer ready
    send_frame(1'b0, 9'h0A5, 8, ^8'hA5, 1'b1, 1);
    repeat (6) @(negedge clk);
    chk("a5_accepted", acc_cnt, 1);
    chk("a5_data",     last_data, 8'hA5);
    chk("a5_ferr",     last_ferr, 0);
    chk("a5_perr",     last_perr, 0);
    chk("a5_valid_pulse_done", valid, 0);
    chk("a5_no_overrun", ovr_cnt, 0);

    // Two-clock low glitch while idle
    drive(1'b0, 1'b0, 2);
    line = 1'b1;
    bmax = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_run > bmax) bmax = busy_run;
    end
    chk("glitch_busy_1to4", (bmax >= 1 && bmax <= 4), 1);
    chk("glitch_no_delivery", acc_cnt, 1);
    chk("glitch_valid_low", valid, 0);
    chk("glitch_idle", busy, 0);

    // 0x3C with a low stop bit
    send_frame(1'b0, 9'h03C, 8, ^8'h3C, 1'b0, 1);
    repeat (20) @(negedge clk);
    chk("fe_accepted", acc_cnt, 2);
    chk("fe_data",     last_data, 8'h3C);
    chk("fe_ferr",     last_ferr, 1);

    // Back-to-back 0x11, 0x22 with consumer stalled
    ready = 1'b0;
    acc0 = acc_cnt; ovr0 = ovr_cnt;
    send_frame(1'b0, 9'h011, 8, ^8'h11, 1'b1, 1);
    send_frame(1'b0, 9'h022, 8, ^8'h22, 1'b1, 1);
    repeat (6) @(negedge clk);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_data_held",  data, 8'h11);
    chk("ovr_ferr_held",  ferr, 0);
    chk("ovr_pulses",     ovr_cnt - ovr0, 1);
    ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", valid, 0);
    chk("ovr_one_accept", acc_cnt - acc0, 1);
    chk("ovr_accepted_data", last_data, 8'h11);

`ifdef UART_RX_CFG_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong for even parity, 1 is right
    send_frame(1'b0, 9'h007, 8, 1'b0, 1'b1, 1);
    repeat (6) @(negedge clk);
    chk("par_bad_data", last_data, 8'h07);
    chk("par_bad_perr", last_perr, 1);
    send_frame(1'b0, 9'h007, 8, 1'b1, 1'b1, 1);
    repeat (6) @(negedge clk);
    chk("par_good_perr", last_perr, 0);
    chk("par_good_count", acc_cnt, acc0 + 3);
`else
    chk("noparity_perr_tied0", perr, 0);
`endif

    // 5 data bits, 2 stop bits: reset during bit 3, then a clean 0x15
    drive(1'b1, 1'b0, CPB);      // start
    drive(1'b1, 1'b1, CPB);      // bit 0
    drive(1'b1, 1'b0, CPB);      // bit 1
    drive(1'b1, 1'b1, CPB);      // bit 2
    drive(1'b1, 1'b0, 4);        // first half of bit 3
    rst5_n = 1'b0; line5 = 1'b1;
    repeat (3) @(negedge clk);
    rst5_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst5_no_delivery", acc5_cnt, 0);
    chk("rst5_valid_low",   valid5, 0);
    chk("rst5_idle",        busy5, 0);
    send_frame(1'b1, 9'h015, 5, ^5'h15, 1'b1, 2);
    repeat (6) @(negedge clk);
    chk("d5_accepted", acc5_cnt, 1);
    chk("d5_data",     last5_data, 5'h15);
    chk("d5_ferr",     last5_ferr, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
